// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the FSM state encoding and the fetch-buffer entry layout.
package fetch_controller_pkg;

   localparam int          PC_W = 32;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT = 2'b00,
      RUN  = 2'b01,
      HALT = 2'b10
   } state_t;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     instr;
      logic            misalign;
   } fb_entry_t;

   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
      return {pc[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-to-decode handshake bundle.
// master drives the head entry, slave returns if_ready.
interface fetch_controller_if;
   import fetch_controller_pkg::*;

   logic            if_valid;
   logic            if_ready;
   logic [31:0]     if_instr;
   logic [PC_W-1:0] if_pc;
   logic            if_misalign;

   modport master (
      output if_valid,
      output if_instr,
      output if_pc,
      output if_misalign,
      input  if_ready
   );

   modport slave (
      input  if_valid,
      input  if_instr,
      input  if_pc,
      input  if_misalign,
      output if_ready
   );

endinterface

// File: rtl/fetch_controller_buffer.sv
// Small synchronous FIFO of fetched entries with a flush input.
// Head reads as all-zero while empty.
module fetch_buffer
   import fetch_controller_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      flush,
   input  logic      push,
   input  fb_entry_t push_data,
   input  logic      pop,
   output fb_entry_t head,
   output logic      valid,
   output logic      full
);

   localparam int PW = (DEPTH > 2) ? 2 : 1;

   fb_entry_t     mem_q [DEPTH];
   logic [PW-1:0] rd_q;
   logic [PW-1:0] wr_q;
   logic [PW:0]   cnt_q;
   logic          do_pop;
   logic          do_push;

   assign valid   = (cnt_q != '0);
   assign full    = (cnt_q == (PW+1)'(DEPTH));
   assign do_pop  = pop & valid;
   assign do_push = push & (~full | do_pop);
   assign head    = valid ? mem_q[rd_q] : '0;

   // Pointer and occupancy update; reset and flush both empty the FIFO.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_pop)
            rd_q <= rd_q + PW'(1);
         if (do_push)
            wr_q <= wr_q + PW'(1);
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Entry storage; a write racing a flush is dropped.
   always_ff @(posedge clk) begin
      if (rst_n && !flush && do_push)
         mem_q[wr_q] <= push_data;
   end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: sequential PC, redirect, halt and
// a small decoupling buffer feeding decode.
module fetch_controller
   import fetch_controller_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [PC_W-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic            halt_req,
   fetch_controller_if.master dec,
   output logic [31:0]     fetch_count
);

   state_t          state_q;
   state_t          state_d;
   logic [PC_W-1:0] fetch_pc_q;
   logic            mis_q;
   logic            pop;
   logic            push_req;
   logic            fb_full;
   logic            fb_valid;
   fb_entry_t       fb_head;
   fb_entry_t       fb_in;

   assign imem_addr = fetch_pc_q;
   assign pop       = dec.if_valid & dec.if_ready;

   assign fb_in.pc       = fetch_pc_q;
   assign fb_in.instr    = imem_rdata;
   assign fb_in.misalign = mis_q;

   // Next state and fetch permission.
   always_comb begin
      state_d  = state_q;
      push_req = 1'b0;
      unique case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (halt_req)
               state_d = HALT;
            else
               push_req = ~fb_full | pop;
         end
         HALT: begin
            if (!halt_req)
               state_d = RUN;
         end
         default: state_d = BOOT;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n)
         state_q <= BOOT;
      else
         state_q <= state_d;
   end

   // Fetch PC and pending misalign flag; redirect beats a push.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         mis_q      <= 1'b0;
      end else if (redirect_valid) begin
         fetch_pc_q <= align_pc(redirect_pc);
         mis_q      <= |redirect_pc[1:0];
      end else if (push_req) begin
         fetch_pc_q <= fetch_pc_q + 32'd4;
         mis_q      <= 1'b0;
      end
   end

   // Count decode handshakes, including ones in a redirect cycle.
   always_ff @(posedge clk) begin
      if (!rst_n)
         fetch_count <= '0;
      else if (pop)
         fetch_count <= fetch_count + 32'd1;
   end

   fetch_buffer #(
      .DEPTH (DEPTH)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (push_req),
      .push_data (fb_in),
      .pop       (pop),
      .head      (fb_head),
      .valid     (fb_valid),
      .full      (fb_full)
   );

   assign dec.if_valid    = fb_valid;
   assign dec.if_instr    = fb_head.instr;
   assign dec.if_pc       = fb_head.pc;
   assign dec.if_misalign = fb_head.misalign;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller (DEPTH=2, RESET_PC=0).
// Cycle vectors plus a random-ready streaming scoreboard.
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic [31:0] fetch_count;
   logic [31:0] mem [128];

   fetch_controller_if dif ();

   fetch_controller #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .dec            (dif.master),
      .fetch_count    (fetch_count)
   );

   always #5 clk = ~clk;

   assign imem_rdata = mem[imem_addr[8:2]];

   typedef struct {
      logic        rst;
      logic        rv;
      logic [31:0] rpc;
      logic        halt;
      logic        rdy;
      logic        ev;
      logic [31:0] epc;
      logic        emis;
      logic [31:0] eaddr;
      logic [31:0] ecnt;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } str_t;

   vec_t vt[$];
   vec_t exp_q[$];
   str_t str_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic logic [31:0] ins(input logic [31:0] a);
      logic [6:0] w;
      w = a[8:2];
      return mem[w];
   endfunction

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic rv, input logic [31:0] rpc,
                      input logic h, input logic rdy, input logic ev,
                      input logic [31:0] epc, input logic emis,
                      input logic [31:0] eaddr, input logic [31:0] ecnt);
      vec_t v;
      v.rst = r; v.rv = rv; v.rpc = rpc; v.halt = h; v.rdy = rdy;
      v.ev = ev; v.epc = epc; v.emis = emis;
      v.eaddr = eaddr; v.ecnt = ecnt;
      vt.push_back(v);
   endtask

   initial begin
      vec_t e;
      str_t s;
      int   nhs;
      logic [31:0] ei;
      for (int i = 0; i < 128; i++)
         mem[i] = 32'h0050_0093 + 32'(i) * 32'h0001_0000;

      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      halt_req = 1'b0; dif.if_ready = 1'b0;

      // reset, boot latency, first fetches
      add(0,0,0,0,1, 0,32'h0,0,32'h0,0);
      add(1,0,0,0,1, 0,32'h0,0,32'h0,0);
      add(1,0,0,0,1, 1,32'h0,0,32'h4,0);
      add(1,0,0,0,1, 1,32'h4,0,32'h8,1);
      add(1,0,0,0,1, 1,32'h8,0,32'hC,2);
      // stall: buffer fills, fetch freezes
      for (int i = 0; i < 5; i++)
         add(1,0,0,0,0, 1,32'h8,0,32'h10,2);
      // redirect with full buffer, then misaligned redirect
      add(1,1,32'h40,0,1, 0,32'h0,0,32'h40,3);
      add(1,0,0,0,0, 1,32'h40,0,32'h44,3);
      add(1,1,32'h42,0,0, 0,32'h0,0,32'h40,3);
      add(1,0,0,0,0, 1,32'h40,1,32'h44,3);
      add(1,0,0,0,1, 1,32'h44,0,32'h48,4);
      add(1,0,0,0,0, 1,32'h44,0,32'h4C,4);
      // halt drains, resumes at held pc
      add(1,0,0,1,1, 1,32'h48,0,32'h4C,5);
      add(1,0,0,1,1, 0,32'h0,0,32'h4C,6);
      add(1,0,0,1,1, 0,32'h0,0,32'h4C,6);
      add(1,0,0,0,1, 0,32'h0,0,32'h4C,6);
      add(1,0,0,0,1, 1,32'h4C,0,32'h50,6);
      add(1,0,0,0,1, 1,32'h50,0,32'h54,7);
      // redirect while halted
      add(1,0,0,1,0, 1,32'h50,0,32'h54,7);
      add(1,1,32'h100,1,0, 0,32'h0,0,32'h100,7);
      add(1,0,0,1,0, 0,32'h0,0,32'h100,7);
      add(1,0,0,0,0, 0,32'h0,0,32'h100,7);
      add(1,0,0,0,0, 1,32'h100,0,32'h104,7);
      // mid-stream reset beats redirect and pop
      add(0,1,32'h80,0,1, 0,32'h0,0,32'h0,0);
      add(1,0,0,0,0, 0,32'h0,0,32'h0,0);
      add(1,0,0,0,0, 1,32'h0,0,32'h4,0);
      for (int i = 0; i < 3; i++)
         add(1,0,0,0,0, 1,32'h0,0,32'h8,0);
      // full buffer pop+push in one cycle
      add(1,0,0,0,1, 1,32'h4,0,32'hC,1);
      add(1,0,0,0,1, 1,32'h8,0,32'h10,2);
      // pc wrap at top of address space
      add(1,1,32'hFFFF_FFFD,0,1, 0,32'h0,0,32'hFFFF_FFFC,3);
      add(1,0,0,0,0, 1,32'hFFFF_FFFC,1,32'h0,3);
      add(1,0,0,0,1, 1,32'h0,0,32'h4,4);

      foreach (vt[i]) begin
         @(negedge clk);
         rst_n = vt[i].rst;
         redirect_valid = vt[i].rv;
         redirect_pc = vt[i].rpc;
         halt_req = vt[i].halt;
         dif.if_ready = vt[i].rdy;
         exp_q.push_back(vt[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         ei = e.ev ? ins(e.epc) : 32'h0;
         check($sformatf("v%0d if_valid", i), 32'(dif.if_valid), 32'(e.ev));
         check($sformatf("v%0d if_pc", i), dif.if_pc, e.epc);
         check($sformatf("v%0d if_instr", i), dif.if_instr, ei);
         check($sformatf("v%0d if_misalign", i), 32'(dif.if_misalign),
               32'(e.emis));
         check($sformatf("v%0d imem_addr", i), imem_addr, e.eaddr);
         check($sformatf("v%0d fetch_count", i), fetch_count, e.ecnt);
      end

      // streaming: accepted entries must follow 0,4,8,...
      for (int i = 0; i < 100; i++) begin
         s.pc = 32'(i) * 32'd4;
         s.instr = ins(s.pc);
         str_q.push_back(s);
      end
      nhs = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         redirect_valid = 1'b0;
         halt_req = 1'b0;
         dif.if_ready = 1'($urandom_range(0, 1));
         #1;
         if (dif.if_valid && dif.if_ready) begin
            nhs++;
            if (str_q.size() == 0) begin
               check("stream underflow", 32'(nhs), 32'd0);
            end else begin
               s = str_q.pop_front();
               check($sformatf("s%0d if_pc", k), dif.if_pc, s.pc);
               check($sformatf("s%0d if_instr", k), dif.if_instr, s.instr);
               check($sformatf("s%0d if_misalign", k),
                     32'(dif.if_misalign), 32'd0);
            end
         end
      end
      @(posedge clk);
      #1;
      check("stream fetch_count", fetch_count, 32'd4 + 32'(nhs));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, fetch-buffer entries; legal values 2 and 4 only.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 imem_addr  output  32  address to instruction memory; that memory reads combinationally, indexing by addr[8:2].
REQ-006 imem_rdata  input  32  instruction word returned in the same cycle.
REQ-007 redirect_valid  input  1  branch/jump taken; 1-cycle pulse or level.
REQ-008 redirect_pc  input  32  target address, sampled when redirect_valid=1.
REQ-009 halt_req  input  1  level; suspends new fetches while high.
REQ-010 if_valid  output  1  buffer head holds a valid instruction.
REQ-011 if_ready  input  1  decode accepts the head this cycle.
REQ-012 if_instr  output  32  head instruction.
REQ-013 if_pc  output  32  address the head instruction was fetched from.
REQ-014 if_misalign  output  1  head came from a redirect target with bits[1:0]!=0.
REQ-015 fetch_count  output  32  number of instructions accepted by decode (if_valid & if_ready).

Function
REQ-016 States: BOOT, RUN, HALT; 2-bit encoding.
- BOOT -> RUN on the first edge with rst_n=1.
- RUN -> HALT on an edge with halt_req=1.
- HALT -> RUN on an edge with halt_req=0.
REQ-017 imem_addr shall equal fetch_pc combinationally in every state.
REQ-018 Push: in RUN with halt_req=0 and buffer not full, {fetch_pc, imem_rdata, misalign flag} enters the tail at the edge, and fetch_pc advances by 4.
REQ-019 No push in BOOT or HALT, or when the buffer is full; fetch_pc holds.
REQ-020 Pop: if_valid & if_ready removes the head at the edge and increments fetch_count.
REQ-021 Push and pop in the same cycle on a full buffer: pop first, push allowed; occupancy unchanged.
REQ-022 if_valid=1 iff occupancy>0; if_instr, if_pc and if_misalign reflect the head; all three are 0 when empty.
REQ-023 Redirect, at the edge with redirect_valid=1:
- buffer flushed (occupancy 0); a same-cycle push is discarded;
- fetch_pc <= {redirect_pc[31:2],2'b00};
- misalign flag <= |redirect_pc[1:0], attached to the next pushed entry only.
REQ-024 Redirect has priority over push; a pop handshake in the same cycle still counts in fetch_count.
REQ-025 Redirect in HALT updates fetch_pc and flushes; the state stays HALT.
REQ-026 fetch_pc arithmetic is 32-bit modulo (32'hFFFFFFFC + 4 = 0); no range check against memory size.
REQ-027 Buffer pointers wrap modulo DEPTH; fetch_count wraps modulo 2^32.
REQ-028 Latency: first if_valid=1 one cycle after BOOT->RUN, i.e. after the 2nd rising edge with rst_n=1.
REQ-029 Entries already buffered when HALT is entered shall still drain to decode.

Reset
REQ-030 rst_n=0 at an edge: state=BOOT, fetch_pc=RESET_PC, occupancy=0, misalign flag=0, fetch_count=0, if_valid=0.
REQ-031 Reset asserted mid-operation overrides redirect, push and pop in that cycle; buffered entries are discarded.

Structure
REQ-032 A shared package holds the state enum, the NOP constant 32'h00000013 and the PC width 32.
REQ-033 One sub-module, fetch_buffer (DEPTH-entry synchronous FIFO, 65-bit entry: pc, instr, misalign, plus a flush input), is instantiated once.
REQ-034 Instruction memory stays outside this block; only imem_addr/imem_rdata connect.

Verification
REQ-035 Reset release, if_ready=1, memory holding 0x00500093 at word 0 -> 2nd edge after release: if_valid=1, if_pc=0, if_instr=00500093; next if_pc=4.
REQ-036 if_ready=0 for 5 cycles in RUN -> occupancy saturates at DEPTH, imem_addr frozen at RESET_PC+4*DEPTH, fetch_count unchanged.
REQ-037 redirect_valid=1, redirect_pc=0x40, with 2 entries buffered -> next cycle if_valid=0, imem_addr=0x40; following cycle if_pc=0x40.
REQ-038 redirect_pc=0x42 -> entry at if_pc=0x40 has if_misalign=1; the entry at 0x44 has if_misalign=0.
REQ-039 halt_req=1 for 3 cycles with 2 entries buffered, if_ready=1 -> both drain, no push, imem_addr constant; on halt_req=0, fetch resumes at the held address.
REQ-040 rst_n=0 for 1 cycle mid-stream with fetch_count=7 -> fetch_count=0, if_valid=0, imem_addr=RESET_PC.
